// File: rtl/seg_scan_decoder_pkg.sv
// Shared segment patterns, digit codes and FSM encodings for the
// seven-segment scan readback path.
package seg_scan_decoder_pkg;

  // Active-low g..a patterns for digits 0..9
  localparam logic [6:0] SEG_D0 = 7'h40;
  localparam logic [6:0] SEG_D1 = 7'h79;
  localparam logic [6:0] SEG_D2 = 7'h24;
  localparam logic [6:0] SEG_D3 = 7'h30;
  localparam logic [6:0] SEG_D4 = 7'h19;
  localparam logic [6:0] SEG_D5 = 7'h12;
  localparam logic [6:0] SEG_D6 = 7'h02;
  localparam logic [6:0] SEG_D7 = 7'h78;
  localparam logic [6:0] SEG_D8 = 7'h00;
  localparam logic [6:0] SEG_D9 = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] CODE_BLANK   = 4'hF;
  localparam logic [3:0] CODE_ILLEGAL = 4'hE;

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HELD   = 2'd2;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of the BCD->7-seg encoder: pattern to digit code,
// flagging anything that is neither a digit nor blank.
module seg_pattern_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] code_o,
  output logic       illegal_o
);

  always_comb begin
    code_o    = CODE_ILLEGAL;
    illegal_o = 1'b0;
    case (seg_i)
      SEG_D0:    code_o = 4'd0;
      SEG_D1:    code_o = 4'd1;
      SEG_D2:    code_o = 4'd2;
      SEG_D3:    code_o = 4'd3;
      SEG_D4:    code_o = 4'd4;
      SEG_D5:    code_o = 4'd5;
      SEG_D6:    code_o = 4'd6;
      SEG_D7:    code_o = 4'd7;
      SEG_D8:    code_o = 4'd8;
      SEG_D9:    code_o = 4'd9;
      SEG_BLANK: code_o = CODE_BLANK;
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors the multiplexed active-low anode/segment bus, captures each slot
// once its pattern has settled, and publishes complete 4-digit frames.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [7:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic [3:0]  frame_err
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [11:0]      prev_q;
  logic [3:0]       mask_q, mask_d;
  logic [15:0]      sh_dig_q, sh_dig_d;
  logic [3:0]       sh_dp_q, sh_dp_d;
  logic [3:0]       sh_err_q, sh_err_d;
  logic [15:0]      digits_q;
  logic [3:0]       dp_q, err_q;
  logic             fv_q;

  logic             change, an_valid, capture, publish;
  logic [1:0]       slot;
  logic [3:0]       code;
  logic             illegal;

  seg_pattern_decode u_dec (
    .seg_i     (seg[6:0]),
    .code_o    (code),
    .illegal_o (illegal)
  );

  assign change  = {an, seg} != prev_q;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    an_valid = 1'b1;
    slot     = 2'd0;
    case (an)
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: an_valid = 1'b0;
    endcase
  end

  // A change (or WAIT) re-evaluates the current bus value as a fresh activation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (state_q == ST_HELD && !change) begin
      state_d = ST_HELD;
    end else if (state_q == ST_SETTLE && !change && an_valid) begin
      cnt_d = cnt_inc;
      if (cnt_inc == CNT_W'(SETTLE_CYCLES)) begin
        capture = 1'b1;
        state_d = ST_HELD;
      end
    end else if (an_valid) begin
      cnt_d = CNT_W'(1);
      if (SETTLE_CYCLES == 1) begin
        capture = 1'b1;
        state_d = ST_HELD;
      end else begin
        state_d = ST_SETTLE;
      end
    end else begin
      state_d = ST_WAIT;
      cnt_d   = '0;
    end
  end

  always_comb begin
    sh_dig_d = sh_dig_q;
    sh_dp_d  = sh_dp_q;
    sh_err_d = sh_err_q;
    mask_d   = mask_q;
    if (capture) begin
      sh_dig_d[slot*4 +: 4] = code;
      sh_dp_d[slot]         = ~seg[7];
      sh_err_d[slot]        = illegal;
      mask_d[slot]          = 1'b1;
    end
  end

  assign publish = capture && (mask_d == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_WAIT;
      cnt_q    <= '0;
      prev_q   <= 12'hFFF;
      mask_q   <= 4'h0;
      sh_dig_q <= 16'hFFFF;
      sh_dp_q  <= 4'h0;
      sh_err_q <= 4'h0;
      digits_q <= 16'hFFFF;
      dp_q     <= 4'h0;
      err_q    <= 4'h0;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= {an, seg};
      sh_dig_q <= sh_dig_d;
      sh_dp_q  <= sh_dp_d;
      sh_err_q <= sh_err_d;
      fv_q     <= publish;
      if (publish) begin
        mask_q   <= 4'h0;
        digits_q <= sh_dig_d;
        dp_q     <= sh_dp_d;
        err_q    <= sh_err_d;
      end else begin
        mask_q   <= mask_d;
      end
    end
  end

  assign digits      = digits_q;
  assign dp          = dp_q;
  assign frame_err   = err_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: a run-length reference model queues
// expected frames; a monitor pops and compares them on every frame_valid.
module tb_seg_scan_decoder;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [7:0]  seg = 8'hFF;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        frame_valid;
  logic [3:0]  frame_err;

  seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .CNT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .seg         (seg),
    .digits      (digits),
    .dp          (dp),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dpv;
    logic [3:0]  err;
    int          cyc;
  } frame_t;

  frame_t      q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  logic [6:0]  pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // reference model state
  logic [11:0] last_v;
  bit          have_last = 0;
  int          run = 0;
  logic [3:0]  m_mask = 4'h0;
  logic [15:0] m_dig = 16'hFFFF;
  logic [3:0]  m_dp = 4'h0;
  logic [3:0]  m_err = 4'h0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int k = 0; k < 10; k++)
      if (pat[k] == s) return {1'b0, 4'(k)};
    if (s == 7'h7F) return {1'b0, 4'hF};
    return {1'b1, 4'hE};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    have_last = 0;
    run       = 0;
    m_mask    = 4'h0;
    m_dig     = 16'hFFFF;
    m_dp      = 4'h0;
    m_err     = 4'h0;
  endtask

  task automatic check_reset_outputs();
    check("rst_digits", 32'(digits), 32'hFFFF);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_valid", 32'(frame_valid), 32'h0);
    check("rst_err", 32'(frame_err), 32'h0);
  endtask

  // One bus value for one clock; the model counts how long it has been stable.
  task automatic step(input logic [3:0] a, input logic [7:0] s);
    logic [11:0] v;
    logic [4:0]  d;
    int          slot;
    @(posedge clk);
    #1;
    an  = a;
    seg = s;
    v   = {a, s};
    if (have_last && v == last_v) run++;
    else run = 1;
    have_last = 1;
    last_v    = v;
    slot = -1;
    for (int i = 0; i < 4; i++)
      if ((~a) == (4'b1 << i)) slot = i;
    if (run == SETTLE && slot >= 0) begin
      d = ref_decode(s[6:0]);
      m_dig[slot*4 +: 4] = d[3:0];
      m_dp[slot]   = ~s[7];
      m_err[slot]  = d[4];
      m_mask[slot] = 1'b1;
      if (m_mask == 4'hF) begin
        q.push_back('{m_dig, m_dp, m_err, cyc + 1});
        m_mask = 4'h0;
      end
    end
  endtask

  task automatic scan(input logic [3:0] a, input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) step(a, s);
  endtask

  task automatic frame4(input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] s2, input logic [7:0] s3);
    scan(4'hE, s0, 8);
    scan(4'hD, s1, 8);
    scan(4'hB, s2, 8);
    scan(4'h7, s3, 8);
  endtask

  task automatic reset_dut();
    step(4'hF, 8'hFF);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      frame_t e;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_frame: got digits=%0h at cycle %0d, expected none", digits, cyc);
      end else begin
        e = q.pop_front();
        check("frame_digits", 32'(digits), 32'(e.dig));
        check("frame_dp", 32'(dp), 32'(e.dpv));
        check("frame_err", 32'(frame_err), 32'(e.err));
        check("frame_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] a;
    logic [7:0] s;
    int         r;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    frame4(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    frame4(8'h90, 8'hFF, 8'h7F, 8'h90);
    frame4(8'hC0, 8'hC0, 8'hC0, 8'h8F);

    for (int i = 0; i < 10; i++) scan(4'hE, (i % 2) ? 8'hF9 : 8'hC0, 3);
    scan(4'hE, 8'hC0, 5);
    scan(4'hD, 8'h99, 8);
    scan(4'hB, 8'h92, 8);
    scan(4'h7, 8'h82, 8);

    scan(4'hE, 8'hF8, 8);
    scan(4'hC, 8'h80, 20);
    scan(4'hD, 8'h80, 8);
    scan(4'hF, 8'hC0, 20);
    scan(4'hB, 8'h24, 8);
    scan(4'h7, 8'h79, 8);

    scan(4'hE, 8'hC0, 8);
    scan(4'hD, 8'hF9, 8);
    scan(4'hB, 8'hA4, 8);
    reset_dut();
    frame4(8'h99, 8'h92, 8'h82, 8'hF8);

    for (int n = 0; n < 160; n++) begin
      r = $urandom_range(0, 99);
      if (r < 10) a = 4'($urandom_range(0, 15));
      else a = ~(4'b1 << $urandom_range(0, 3));
      r = $urandom_range(0, 99);
      if (r < 60) s = {1'($urandom_range(0, 1)), pat[$urandom_range(0, 9)]};
      else if (r < 75) s = {1'($urandom_range(0, 1)), 7'h7F};
      else s = 8'($urandom_range(0, 255));
      scan(a, s, $urandom_range(1, 8));
    end

    scan(4'hF, 8'hFF, 6);
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
